// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types, FSM encoding and default character-range constants
// for the RC4 keystream/decrypt engine.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  // One state per memory access of the per-byte PRGA step, plus run control.
  typedef enum logic [3:0] {
    IDLE,
    ADDR_I,
    LATCH_I,
    ADDR_J,
    LATCH_J,
    SWAP_I,
    SWAP_J,
    ADDR_F,
    LATCH_F,
    WRITE_OUT,
    DONE,
    FAIL
  } state_t;

  localparam byte_t CHAR_LO_DEFAULT = 8'h61;  // 'a'
  localparam byte_t CHAR_HI_DEFAULT = 8'h7A;  // 'z'
  localparam byte_t SPACE_CHAR      = 8'h20;

  // Address width for a message of msg_len bytes; never narrower than 1 bit.
  function automatic int msg_aw(input int msg_len);
    return (msg_len > 1) ? $clog2(msg_len) : 1;
  endfunction

endpackage

// File: rtl/rc4_decrypt_core_if.sv
// rc4_decrypt_core_if: run handshake plus the S-RAM, encrypted-ROM and
// plaintext-RAM buses of the decrypt engine. The master modport is the
// engine itself; the slave modport is the controller/memory side.
interface rc4_decrypt_core_if
  import rc4_pkg::*;
#(
  parameter int MSG_AW = 5
);

  // Run control
  logic              start;
  logic              busy;
  logic              done;
  logic              key_ok;
  logic              key_fail;

  // S-RAM (synchronous read, 1-cycle latency)
  byte_t             s_addr;
  byte_t             s_wdata;
  logic              s_wren;
  byte_t             s_rdata;

  // Encrypted-message ROM (1-cycle latency)
  logic [MSG_AW-1:0] msg_addr;
  byte_t             msg_rdata;

  // Plaintext output RAM
  logic [MSG_AW-1:0] out_addr;
  byte_t             out_wdata;
  logic              out_wren;

  modport master (
    input  start, s_rdata, msg_rdata,
    output busy, done, key_ok, key_fail,
    output s_addr, s_wdata, s_wren, msg_addr,
    output out_addr, out_wdata, out_wren
  );

  modport slave (
    output start, s_rdata, msg_rdata,
    input  busy, done, key_ok, key_fail,
    input  s_addr, s_wdata, s_wren, msg_addr,
    input  out_addr, out_wdata, out_wren
  );

endinterface

// File: rtl/rc4_char_check.sv
// rc4_char_check: combinational plaintext filter. A byte is valid when it
// lies in [CHAR_LO, CHAR_HI], or is a space and spaces are allowed.
module rc4_char_check
  import rc4_pkg::*;
#(
  parameter byte_t CHAR_LO     = CHAR_LO_DEFAULT,
  parameter byte_t CHAR_HI     = CHAR_HI_DEFAULT,
  parameter bit    ALLOW_SPACE = 1'b1
) (
  input  byte_t data,
  output logic  valid
);

  logic in_range;
  logic is_space;

  assign in_range = (data >= CHAR_LO) && (data <= CHAR_HI);
  assign is_space = ALLOW_SPACE && (data == SPACE_CHAR);
  assign valid    = in_range || is_space;

endmodule

// File: rtl/rc4_decrypt_core.sv
// rc4_decrypt_core: RC4 PRGA + XOR decrypt over MSG_LEN bytes of an external
// encrypted ROM, writing plaintext to an external RAM. The S array is assumed
// already key-scheduled in the external S-RAM. Each byte takes nine cycles.
//
// Optional feature macro: RC4_CHAR_CHECK_EN
//   defined   - each plaintext byte is range-checked; a reject ends the run
//               in FAIL (key_fail=1) after that byte is written.
//   undefined - no check logic; every run ends in DONE, key_fail stays 0.
module rc4_decrypt_core
  import rc4_pkg::*;
#(
  parameter int    MSG_LEN     = 32,
  parameter int    MSG_AW      = msg_aw(MSG_LEN),
  parameter byte_t CHAR_LO     = CHAR_LO_DEFAULT,
  parameter byte_t CHAR_HI     = CHAR_HI_DEFAULT,
  parameter bit    ALLOW_SPACE = 1'b1
) (
  input logic                clk,
  input logic                reset,
  rc4_decrypt_core_if.master bus
);

  // Elaboration-time sanity checks on the configuration.
  if (MSG_LEN < 1 || MSG_LEN > 256) begin : g_bad_len
    $error("rc4_decrypt_core: MSG_LEN must be 1..256");
  end
  if (MSG_AW < msg_aw(MSG_LEN)) begin : g_bad_aw
    $error("rc4_decrypt_core: MSG_AW too narrow for MSG_LEN");
  end
  if (CHAR_LO > CHAR_HI && !ALLOW_SPACE) begin : g_empty_set
    $error("rc4_decrypt_core: character filter accepts no byte");
  end

  state_t            state_q, state_d;
  byte_t             i_q, j_q;      // PRGA indices, wrap mod 256
  byte_t             si_q, sj_q;    // S[i], S[j] captured before the swap
  byte_t             f_q;           // keystream byte S[S[i]+S[j]]
  byte_t             m_q;           // encrypted message byte
  logic [MSG_AW-1:0] k_q;           // message byte index
  byte_t             plain;
  logic              byte_ok;
  logic              last_byte;

  assign plain     = f_q ^ m_q;
  assign last_byte = (k_q == MSG_AW'(MSG_LEN - 1));

`ifdef RC4_CHAR_CHECK_EN
  rc4_char_check #(
    .CHAR_LO     (CHAR_LO),
    .CHAR_HI     (CHAR_HI),
    .ALLOW_SPACE (ALLOW_SPACE)
  ) u_char_check (
    .data  (plain),
    .valid (byte_ok)
  );
`else
  assign byte_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values that existed before the clock edge.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // PRGA datapath registers: pointer init on start, captures on LATCH_*,
  // advance to the next byte after a clean WRITE_OUT.
  always_ff @(posedge clk) begin
    // NOTE: only these pointer/byte registers are reset; the S array and the
    // message/plaintext memories live outside and keep their contents.
    if (reset) begin
      i_q  <= '0;
      j_q  <= '0;
      k_q  <= '0;
      si_q <= '0;
      sj_q <= '0;
      f_q  <= '0;
      m_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, FAIL: begin
          if (bus.start) begin
            i_q <= 8'd1;
            j_q <= '0;
            k_q <= '0;
          end
        end
        LATCH_I: begin
          si_q <= bus.s_rdata;
          j_q  <= j_q + bus.s_rdata;
          m_q  <= bus.msg_rdata;
        end
        LATCH_J: sj_q <= bus.s_rdata;
        LATCH_F: f_q  <= bus.s_rdata;
        WRITE_OUT: begin
          if (byte_ok && !last_byte) begin
            k_q <= k_q + MSG_AW'(1);
            i_q <= i_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode from the current state and registers.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // through the case statement can infer a latch.
    state_d       = state_q;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.key_ok    = 1'b0;
    bus.key_fail  = 1'b0;
    bus.s_addr    = '0;
    bus.s_wdata   = '0;
    bus.s_wren    = 1'b0;
    bus.msg_addr  = '0;
    bus.out_addr  = '0;
    bus.out_wdata = '0;
    bus.out_wren  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = ADDR_I;
      end
      ADDR_I: begin
        bus.busy     = 1'b1;
        bus.s_addr   = i_q;
        bus.msg_addr = k_q;
        state_d      = LATCH_I;
      end
      LATCH_I: begin
        bus.busy = 1'b1;
        state_d  = ADDR_J;
      end
      ADDR_J: begin
        bus.busy   = 1'b1;
        bus.s_addr = j_q;
        state_d    = LATCH_J;
      end
      LATCH_J: begin
        bus.busy = 1'b1;
        state_d  = SWAP_I;
      end
      // Write enables are masked by reset so an aborting edge never commits
      // a write; when i==j both swaps hit one address with equal data.
      SWAP_I: begin
        bus.busy    = 1'b1;
        bus.s_addr  = i_q;
        bus.s_wdata = sj_q;
        bus.s_wren  = !reset;
        state_d     = SWAP_J;
      end
      SWAP_J: begin
        bus.busy    = 1'b1;
        bus.s_addr  = j_q;
        bus.s_wdata = si_q;
        bus.s_wren  = !reset;
        state_d     = ADDR_F;
      end
      ADDR_F: begin
        bus.busy   = 1'b1;
        bus.s_addr = si_q + sj_q;
        state_d    = LATCH_F;
      end
      LATCH_F: begin
        bus.busy = 1'b1;
        state_d  = WRITE_OUT;
      end
      WRITE_OUT: begin
        bus.busy      = 1'b1;
        bus.out_addr  = k_q;
        bus.out_wdata = plain;
        bus.out_wren  = !reset;
        if (!byte_ok)       state_d = FAIL;
        else if (last_byte) state_d = DONE;
        else                state_d = ADDR_I;
      end
      DONE: begin
        bus.done   = 1'b1;
        bus.key_ok = 1'b1;
        if (bus.start) state_d = ADDR_I;
      end
      FAIL: begin
        bus.done = 1'b1;
`ifdef RC4_CHAR_CHECK_EN
        bus.key_fail = 1'b1;
`endif
        if (bus.start) state_d = ADDR_I;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// tb_rc4_decrypt_core: two engines (MSG_LEN=2 and MSG_LEN=256) with
// behavioural S-RAM / ROM / output-RAM models, checked against a plain RC4
// PRGA reference model. Expectations follow RC4_CHAR_CHECK_EN if defined.
module tb_rc4_decrypt_core;
  import rc4_pkg::*;

  localparam int LEN_A = 2;
  localparam int LEN_B = 256;
  localparam int AW_A  = 1;
  localparam int AW_B  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  rc4_decrypt_core_if #(.MSG_AW(AW_A)) bus_a ();
  rc4_decrypt_core_if #(.MSG_AW(AW_B)) bus_b ();

  rc4_decrypt_core #(.MSG_LEN(LEN_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  rc4_decrypt_core #(.MSG_LEN(LEN_B)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  // Memory models, index 0 = dut_a, 1 = dut_b
  byte_t s_mem    [2][256];
  byte_t msg_mem  [2][256];
  byte_t out_mem  [2][256];
  int    out_hits [2][256] = '{default: 0};
  int    s_writes [2]      = '{0, 0};
  int    out_writes [2]    = '{0, 0};

  always @(posedge clk) begin
    if (bus_a.s_wren) begin
      s_mem[0][bus_a.s_addr] <= bus_a.s_wdata;
      s_writes[0]            <= s_writes[0] + 1;
    end
    bus_a.s_rdata   <= s_mem[0][bus_a.s_addr];
    bus_a.msg_rdata <= msg_mem[0][bus_a.msg_addr];
    if (bus_a.out_wren) begin
      out_mem[0][bus_a.out_addr]  <= bus_a.out_wdata;
      out_hits[0][bus_a.out_addr] <= out_hits[0][bus_a.out_addr] + 1;
      out_writes[0]               <= out_writes[0] + 1;
    end
    if (bus_b.s_wren) begin
      s_mem[1][bus_b.s_addr] <= bus_b.s_wdata;
      s_writes[1]            <= s_writes[1] + 1;
    end
    bus_b.s_rdata   <= s_mem[1][bus_b.s_addr];
    bus_b.msg_rdata <= msg_mem[1][bus_b.msg_addr];
    if (bus_b.out_wren) begin
      out_mem[1][bus_b.out_addr]  <= bus_b.out_wdata;
      out_hits[1][bus_b.out_addr] <= out_hits[1][bus_b.out_addr] + 1;
      out_writes[1]               <= out_writes[1] + 1;
    end
  end

  // ---------------- signal access helpers ----------------
  function automatic logic sig_done(input int d);
    return (d == 0) ? bus_a.done : bus_b.done;
  endfunction
  function automatic logic [1:0] sig_status(input int d);
    return (d == 0) ? {bus_a.key_ok, bus_a.key_fail} : {bus_b.key_ok, bus_b.key_fail};
  endfunction
  function automatic logic sig_out_wren(input int d);
    return (d == 0) ? bus_a.out_wren : bus_b.out_wren;
  endfunction
  function automatic int sig_out_addr(input int d);
    return (d == 0) ? int'(bus_a.out_addr) : int'(bus_b.out_addr);
  endfunction
  task automatic set_start(input int d, input logic v);
    if (d == 0) bus_a.start = v;
    else        bus_b.start = v;
  endtask

  // ---------------- reference model ----------------
  byte_t exp_out [256];
  byte_t exp_ks  [256];
  byte_t exp_s   [256];
  int    exp_fail;
  int    exp_nb;
  byte_t pt      [256];

  function automatic bit printable(input byte_t b);
    return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
  endfunction

  function automatic byte_t pick_printable();
    int r;
    r = $urandom_range(26, 0);
    return (r == 26) ? 8'h20 : byte_t'(8'h61 + r);
  endfunction

  // Textbook RC4 PRGA on a copy of the current S contents.
  task automatic model(input int d, input int len, input bit stop_on_fail);
    byte_t s [256];
    byte_t i, j, t, idx;
    for (int n = 0; n < 256; n++) s[n] = s_mem[d][n];
    i = 0; j = 0; exp_fail = -1; exp_nb = 0;
    for (int n = 0; n < len; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      idx = s[i] + s[j];
      exp_ks[n]  = s[idx];
      exp_out[n] = exp_ks[n] ^ msg_mem[d][n];
      exp_nb++;
      if (stop_on_fail && !printable(exp_out[n])) begin
`ifdef RC4_CHAR_CHECK_EN
        exp_fail = n;
        break;
`endif
      end
    end
    for (int n = 0; n < 256; n++) exp_s[n] = s[n];
  endtask

  // Encrypt the plaintext in pt[] with the keystream the current S yields.
  task automatic make_message(input int d, input int len);
    model(d, len, 1'b0);
    for (int n = 0; n < len; n++) msg_mem[d][n] = pt[n] ^ exp_ks[n];
    model(d, len, 1'b1);
  endtask

  function automatic int exp_latency(input int len);
    return (exp_fail < 0) ? 9 * len : 9 * (exp_fail + 1);
  endfunction
  function automatic logic [1:0] exp_status();
    return (exp_fail < 0) ? 2'b10 : 2'b01;
  endfunction
  function automatic int out_diff(input int d);
    for (int n = 0; n < exp_nb; n++) if (out_mem[d][n] !== exp_out[n]) return n;
    return -1;
  endfunction
  function automatic int s_diff(input int d);
    for (int n = 0; n < 256; n++) if (s_mem[d][n] !== exp_s[n]) return n;
    return -1;
  endfunction

  task automatic load_identity(input int d);
    for (int n = 0; n < 256; n++) s_mem[d][n] = byte_t'(n);
  endtask
  task automatic load_perm(input int d);
    byte_t t;
    int r;
    load_identity(d);
    for (int n = 255; n > 0; n--) begin
      r = $urandom_range(n, 0);
      t = s_mem[d][n]; s_mem[d][n] = s_mem[d][r]; s_mem[d][r] = t;
    end
  endtask

  // ---------------- run driver ----------------
  int lat;
  int first_out;

  // Pulse start, count edges from the sampling edge until done is seen.
  // glitch_at > 0 raises start again for one cycle mid-run.
  task automatic run(input int d, input int glitch_at);
    int budget;
    bit glitched;
    budget = 9 * LEN_B + 50;
    glitched = 1'b0;
    lat = -1;
    first_out = -1;
    @(negedge clk); set_start(d, 1'b1);
    @(posedge clk); #1; set_start(d, 1'b0);
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (glitched) begin set_start(d, 1'b0); glitched = 1'b0; end
      if (sig_out_wren(d) && first_out < 0) first_out = sig_out_addr(d);
      if (sig_done(d)) begin lat = n; break; end
      if (n == glitch_at) begin set_start(d, 1'b1); glitched = 1'b1; end
    end
    set_start(d, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; bus_a.start = 1'b0; bus_b.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({bus_a.busy, bus_a.done, bus_a.key_ok, bus_a.key_fail} !== 4'b0) begin
      n_bad++; $display("FAIL reset_status_a: got %b expected 0000", {bus_a.busy, bus_a.done, bus_a.key_ok, bus_a.key_fail}); end
    n_cmp++; if ({bus_a.s_wren, bus_a.out_wren} !== 2'b0) begin
      n_bad++; $display("FAIL reset_wren_a: got %b expected 00", {bus_a.s_wren, bus_a.out_wren}); end
    n_cmp++; if ({bus_a.s_addr, bus_a.s_wdata, bus_a.msg_addr, bus_a.out_addr, bus_a.out_wdata} !== '0) begin
      n_bad++; $display("FAIL reset_bus_a: got %h expected 0", {bus_a.s_addr, bus_a.s_wdata, bus_a.msg_addr, bus_a.out_addr, bus_a.out_wdata}); end
    n_cmp++; if ({bus_b.busy, bus_b.done, bus_b.key_ok, bus_b.key_fail, bus_b.s_wren, bus_b.out_wren,
                  bus_b.s_addr, bus_b.s_wdata, bus_b.msg_addr, bus_b.out_addr, bus_b.out_wdata} !== '0) begin
      n_bad++; $display("FAIL reset_all_b: outputs not all zero"); end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({bus_a.busy, bus_a.done} !== 2'b0) begin
      n_bad++; $display("FAIL idle_no_start: busy/done got %b expected 00", {bus_a.busy, bus_a.done}); end
  endtask

  task automatic test_known_vector(input string tag, input int glitch_at);
    int o0, w0, idx;
    load_identity(0);
    msg_mem[0][0] = 8'h63; msg_mem[0][1] = 8'h64;
    model(0, LEN_A, 1'b1);
    o0 = out_writes[0]; w0 = s_writes[0];
    run(0, glitch_at);
    n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL %s_latency: got %0d expected 18", tag, lat); end
    n_cmp++; if ({out_mem[0][0], out_mem[0][1]} !== 16'h6161) begin
      n_bad++; $display("FAIL %s_plaintext: got %h expected 6161", tag, {out_mem[0][0], out_mem[0][1]}); end
    n_cmp++; if ({s_mem[0][2], s_mem[0][3]} !== 16'h0302) begin
      n_bad++; $display("FAIL %s_swap: s[2],s[3] got %h expected 0302", tag, {s_mem[0][2], s_mem[0][3]}); end
    n_cmp++; if (sig_status(0) !== 2'b10) begin
      n_bad++; $display("FAIL %s_status: ok/fail got %b expected 10", tag, sig_status(0)); end
    n_cmp++; if (out_writes[0] - o0 !== 2 || s_writes[0] - w0 !== 4) begin
      n_bad++; $display("FAIL %s_write_count: out %0d s %0d expected 2 4", tag, out_writes[0] - o0, s_writes[0] - w0); end
    idx = out_diff(0);
    n_cmp++; if (idx >= 0) begin
      n_bad++; $display("FAIL %s_model: out[%0d] got %h expected %h", tag, idx, out_mem[0][idx], exp_out[idx]); end
  endtask

  task automatic test_char_reject();
    int o0, w_done;
    load_identity(0);
    msg_mem[0][0] = 8'h00; msg_mem[0][1] = 8'h64;
    model(0, LEN_A, 1'b1);
    o0 = out_writes[0];
    run(0, 0);
    w_done = s_writes[0];
    n_cmp++; if (out_mem[0][0] !== 8'h02) begin
      n_bad++; $display("FAIL reject_byte0: got %h expected 02", out_mem[0][0]); end
`ifdef RC4_CHAR_CHECK_EN
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL reject_latency: got %0d expected 9", lat); end
    n_cmp++; if (sig_status(0) !== 2'b01) begin
      n_bad++; $display("FAIL reject_status: ok/fail got %b expected 01", sig_status(0)); end
    n_cmp++; if (out_writes[0] - o0 !== 1) begin
      n_bad++; $display("FAIL reject_out_writes: got %0d expected 1", out_writes[0] - o0); end
`else
    n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL nocheck_latency: got %0d expected 18", lat); end
    n_cmp++; if (sig_status(0) !== 2'b10) begin
      n_bad++; $display("FAIL nocheck_status: ok/fail got %b expected 10", sig_status(0)); end
    n_cmp++; if (out_writes[0] - o0 !== 2) begin
      n_bad++; $display("FAIL nocheck_out_writes: got %0d expected 2", out_writes[0] - o0); end
`endif
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (s_writes[0] !== w_done || bus_a.done !== 1'b1) begin
      n_bad++; $display("FAIL post_done_quiet: s writes %0d expected %0d, done %b", s_writes[0], w_done, bus_a.done); end
  endtask

  task automatic test_restart_in_done();
    int idx;
    for (int n = 0; n < LEN_A; n++) pt[n] = pick_printable();
    make_message(0, LEN_A);
    run(0, 0);
    n_cmp++; if (first_out !== 0) begin n_bad++; $display("FAIL restart_first_addr: got %0d expected 0", first_out); end
    n_cmp++; if (lat !== exp_latency(LEN_A) || sig_status(0) !== exp_status()) begin
      n_bad++; $display("FAIL restart_result: lat %0d status %b expected %0d %b", lat, sig_status(0), exp_latency(LEN_A), exp_status()); end
    idx = out_diff(0);
    n_cmp++; if (idx >= 0) begin
      n_bad++; $display("FAIL restart_plaintext: out[%0d] got %h expected %h", idx, out_mem[0][idx], exp_out[idx]); end
    idx = s_diff(0);
    n_cmp++; if (idx >= 0) begin
      n_bad++; $display("FAIL restart_s_final: s[%0d] got %h expected %h", idx, s_mem[0][idx], exp_s[idx]); end
  endtask

  task automatic test_reset_mid_run();
    int o0;
    load_identity(0);
    msg_mem[0][0] = 8'h63; msg_mem[0][1] = 8'h64;
    o0 = out_writes[0];
    @(negedge clk); bus_a.start = 1'b1;
    @(posedge clk); #1; bus_a.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    // Byte 1, SWAP_J: would write s[3] = 2.
    n_cmp++; if ({bus_a.s_wren, bus_a.s_addr, bus_a.s_wdata} !== {1'b1, 8'h03, 8'h02}) begin
      n_bad++; $display("FAIL swap_j_strobe: wren/addr/data got %b/%h/%h expected 1/03/02", bus_a.s_wren, bus_a.s_addr, bus_a.s_wdata); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({bus_a.busy, bus_a.done, bus_a.key_ok, bus_a.key_fail, bus_a.s_wren, bus_a.out_wren,
                  bus_a.s_addr, bus_a.s_wdata, bus_a.msg_addr, bus_a.out_addr, bus_a.out_wdata} !== '0) begin
      n_bad++; $display("FAIL abort_outputs: outputs not all zero after reset edge"); end
    n_cmp++; if ({s_mem[0][2], s_mem[0][3]} !== 16'h0303) begin
      n_bad++; $display("FAIL abort_no_swap_j: s[2],s[3] got %h expected 0303", {s_mem[0][2], s_mem[0][3]}); end
    n_cmp++; if (out_writes[0] - o0 !== 1) begin
      n_bad++; $display("FAIL abort_out_writes: got %0d expected 1", out_writes[0] - o0); end
    @(negedge clk); reset = 1'b0;
    // A fresh run must behave as if pointers were cleared.
    test_known_vector("post_abort", 0);
  endtask

  task automatic test_msg256_identity();
    int snap [256];
    int o0, idx, bad_hit;
    load_identity(1);
    for (int n = 0; n < LEN_B; n++) pt[n] = pick_printable();
    make_message(1, LEN_B);
    for (int n = 0; n < 256; n++) snap[n] = out_hits[1][n];
    o0 = out_writes[1];
    run(1, 0);
    n_cmp++; if (lat !== 2304) begin n_bad++; $display("FAIL len256_latency: got %0d expected 2304", lat); end
    n_cmp++; if (sig_status(1) !== 2'b10) begin
      n_bad++; $display("FAIL len256_status: ok/fail got %b expected 10", sig_status(1)); end
    n_cmp++; if (out_writes[1] - o0 !== 256) begin
      n_bad++; $display("FAIL len256_out_writes: got %0d expected 256", out_writes[1] - o0); end
    bad_hit = -1;
    for (int n = 255; n >= 0; n--) if (out_hits[1][n] - snap[n] != 1) bad_hit = n;
    n_cmp++; if (bad_hit >= 0) begin
      n_bad++; $display("FAIL len256_addr_once: addr %0d written %0d times expected 1", bad_hit, out_hits[1][bad_hit] - snap[bad_hit]); end
    idx = out_diff(1);
    n_cmp++; if (idx >= 0) begin
      n_bad++; $display("FAIL len256_plaintext: out[%0d] got %h expected %h", idx, out_mem[1][idx], exp_out[idx]); end
  endtask

  task automatic test_random_keys();
    int o0, idx, bad_pos;
    for (int it = 0; it < 3; it++) begin
      load_perm(1);
      for (int n = 0; n < LEN_B; n++) pt[n] = pick_printable();
      bad_pos = -1;
      if (it > 0) begin
        bad_pos = (it == 1) ? $urandom_range(254, 1) : 255;
        pt[bad_pos] = byte_t'($urandom_range(8'hFF, 8'h7B));
      end
      make_message(1, LEN_B);
      o0 = out_writes[1];
      run(1, 0);
      n_cmp++; if (lat !== exp_latency(LEN_B)) begin
        n_bad++; $display("FAIL random%0d_latency: got %0d expected %0d", it, lat, exp_latency(LEN_B)); end
      n_cmp++; if (sig_status(1) !== exp_status()) begin
        n_bad++; $display("FAIL random%0d_status: ok/fail got %b expected %b", it, sig_status(1), exp_status()); end
      n_cmp++; if (out_writes[1] - o0 !== exp_nb) begin
        n_bad++; $display("FAIL random%0d_out_writes: got %0d expected %0d", it, out_writes[1] - o0, exp_nb); end
      idx = out_diff(1);
      n_cmp++; if (idx >= 0) begin
        n_bad++; $display("FAIL random%0d_plaintext: out[%0d] got %h expected %h", it, idx, out_mem[1][idx], exp_out[idx]); end
      idx = s_diff(1);
      n_cmp++; if (idx >= 0) begin
        n_bad++; $display("FAIL random%0d_s_final: s[%0d] got %h expected %h", it, idx, s_mem[1][idx], exp_s[idx]); end
    end
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    for (int n = 0; n < 256; n++) begin
      msg_mem[0][n] = '0; msg_mem[1][n] = '0;
    end
    test_reset();
    test_known_vector("known", 0);
    test_char_reject();
    test_known_vector("mid_start", 5);
    test_restart_in_done();
    test_reset_mid_run();
    test_msg256_identity();
    test_random_keys();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rc4_decrypt_core.md
# rc4_decrypt_core

Parametrised RC4 keystream-generation and decrypt engine: after the S-array has been initialised and key-scheduled, it runs the PRGA over a message of `MSG_LEN` bytes. For each byte it XORs the keystream with the encrypted ROM byte, writes the plaintext to the output RAM, and optionally checks the result against a printable-character range. It sits after the key-schedule loop in the key-search datapath. It reports done/pass/fail so the top-level key-search controller can advance to the next key.

## Interface
- `MSG_LEN`, 32, message length in bytes, legal 1..256
- `MSG_AW`, `$clog2(MSG_LEN)` (min 1), message/output address width
- `CHAR_LO`, 8'h61, lowest accepted plaintext byte
- `CHAR_HI`, 8'h7A, highest accepted plaintext byte
- `ALLOW_SPACE`, 1, when 1 byte 8'h20 is also accepted

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a run; sampled only in IDLE
- `busy`  out  1  high from the cycle after start until DONE/FAIL is entered
- `done`  out  1  level, high in DONE or FAIL until the next accepted start
- `key_ok`  out  1  high in DONE only
- `key_fail`  out  1  high in FAIL only
- `s_addr`  out  8  S-RAM address
- `s_wdata`  out  8  S-RAM write data
- `s_wren`  out  1  S-RAM write enable
- `s_rdata`  in  8  S-RAM read data, 1-cycle synchronous latency
- `msg_addr`  out  MSG_AW  encrypted-ROM address
- `msg_rdata`  in  8  encrypted-ROM data, 1-cycle latency
- `out_addr`  out  MSG_AW  plaintext-RAM address
- `out_wdata`  out  8  plaintext byte
- `out_wren`  out  1  plaintext-RAM write enable

## Operation
- Internal registers: i, j (8-bit, mod-256 wrap), k (MSG_AW bits), si, sj, f, m (8-bit).
- On start in IDLE: i←1, j←0, k←0, then go to ADDR_I.
- Per-byte sequence, 9 states, one cycle each:
  - ADDR_I: s_addr=i, msg_addr=k.
  - LATCH_I: at the end of the cycle, si←s_rdata, j←j+s_rdata, m←msg_rdata.
  - ADDR_J: s_addr=j.
  - LATCH_J: sj←s_rdata.
  - SWAP_I: s_addr=i, s_wdata=sj, s_wren=1.
  - SWAP_J: s_addr=j, s_wdata=si, s_wren=1.
  - ADDR_F: s_addr=si+sj (8-bit truncation).
  - LATCH_F: f←s_rdata.
  - WRITE_OUT: out_addr=k, out_wdata=f^m, out_wren=1.
- Transitions out of WRITE_OUT:
  - If the char check fails: go to FAIL. The failing byte is still written.
  - Else if k==MSG_LEN-1: go to DONE.
  - Else k←k+1, i←i+1, go to ADDR_I.
- When i==j, both swap writes target the same address; the final value is si, which equals sj, so this is correct.
- DONE/FAIL hold until a start arrives, then behave exactly as IDLE+start. start in any other state is ignored.
- Write enables are asserted only in SWAP_I, SWAP_J and WRITE_OUT. All strobes are decoded combinationally from state and registers, with no glitching requirement beyond single-clock synchronous use.

## Timing
- Reset value of every output: 0 (addresses, data, enables, busy, done, key_ok, key_fail). State returns to IDLE.
- Reset mid-run aborts on that edge. No S or output writes occur after the reset edge, and i/j/k are cleared.
- Latency: the first ADDR_I is the cycle after start is sampled. done rises 9·MSG_LEN cycles after the start-sampling cycle on a full pass.
- A fail on byte n gives done 9·(n+1) cycles after start.
- k wraps never: MSG_LEN=256 uses MSG_AW=8 and terminates at k=255.

## Configuration
- `RC4_CHAR_CHECK_EN` defined:
  - WRITE_OUT byte accepted iff CHAR_LO≤byte≤CHAR_HI, or (ALLOW_SPACE and byte==8'h20).
  - Reject → FAIL with key_fail=1.
- Not defined: no check logic; every run ends in DONE with key_ok=1, and key_fail is tied 0.

## Structure
- Package `rc4_pkg`: `state_t` enum (IDLE, ADDR_I, LATCH_I, ADDR_J, LATCH_J, SWAP_I, SWAP_J, ADDR_F, LATCH_F, WRITE_OUT, DONE, FAIL), `byte_t` typedef, default CHAR_LO/CHAR_HI/space constants.
- One sub-module, `rc4_char_check` (parametrised by CHAR_LO/CHAR_HI/ALLOW_SPACE, combinational byte→valid). It is instantiated only under `RC4_CHAR_CHECK_EN`.

## Test plan
- Identity S (s[n]=n), MSG_LEN=2, msg={8'h63, 8'h64}:
  - byte0: f=2, out[0]=8'h61.
  - byte1: i=2, j=3, swap gives s[2]=3, s[3]=2; f=s[5]=5, out[1]=8'h61.
  - Result: key_ok=1, done exactly 18 cycles after start.
- Same S, msg[0]=8'h00 with the macro defined: out[0]=8'h02 written, key_fail=1, done 9 cycles after start, no further S writes.
- Same stimulus as the previous case without the macro: the run completes, key_ok=1, key_fail=0.
- reset asserted in SWAP_J of byte 1: all outputs are 0 on the next cycle, and the S-RAM shadow shows no write to s[j] for that byte.
- start pulsed in the middle of a run is ignored (the run completes normally). A start pulsed in DONE restarts with i=1, j=0, and the first out_addr is 0.
- MSG_LEN=256, identity S: 256 output writes occur, k ends at 255, done arrives after 2304 cycles, and there is no out_addr wrap write.
